// File: rtl/nonce_uplink_tx_pkg.sv
// Shared constants, FSM encoding and bit-period helper for the nonce uplink transmitter.
package nonce_uplink_tx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned NONCE_BYTES    = 4;
  localparam int unsigned NONCE_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per UART bit, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Show-ahead FIFO of found nonces; a push while full is accepted only when a pop frees a slot.
module nonce_fifo
  import nonce_uplink_tx_pkg::*;
#(
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [NONCE_W-1:0]   din,
  input  logic                 pop,
  output logic [NONCE_W-1:0]   dout,
  output logic [FIFO_LOG2:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned DEPTH = 2 ** FIFO_LOG2;
  localparam int unsigned CNT_W = FIFO_LOG2 + 1;

  logic [NONCE_W-1:0]   mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers are exactly FIFO_LOG2 bits wide, so they wrap modulo depth on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nonce_uplink_tx.sv
// Queues golden nonces and sends each one as four 8N1 bytes, low byte first, on TxD.
module nonce_uplink_tx
  import nonce_uplink_tx_pkg::*;
#(
  parameter int unsigned comm_clk_frequency = 80_000_000,
  parameter int unsigned baud_rate          = 115_200,
  parameter int unsigned FIFO_LOG2          = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NONCE_W-1:0]   nonce_in,
  input  logic                 new_nonce,
  output logic                 TxD,
  output logic                 busy,
  output logic                 overflow,
  output logic [FIFO_LOG2:0]   fifo_count
);

  localparam int unsigned DIV    = calc_div(comm_clk_frequency, baud_rate);
  localparam int unsigned DIV_W  = $clog2(DIV);
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
  localparam int unsigned BYTE_W = $clog2(NONCE_BYTES);

  tx_state_t           state, state_next;
  logic [DIV_W-1:0]    baud_cnt, baud_cnt_next;
  logic [BIT_W-1:0]    bit_idx, bit_idx_next;
  logic [BYTE_W-1:0]   byte_idx, byte_idx_next;
  logic [NONCE_W-1:0]  shreg, shreg_next;
  logic                pop_c;
  logic                txd_c;
  logic                baud_tick_c;
  logic [NONCE_W-1:0]  fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;

  nonce_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (new_nonce),
    .din     (nonce_in),
    .pop     (pop_c),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_tick_c = (baud_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      byte_idx <= byte_idx_next;
      shreg    <= shreg_next;
    end
  end

  // Data bits leave from shreg[0]; shifting after every data bit walks bytes low to high.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    byte_idx_next = byte_idx;
    shreg_next    = shreg;
    pop_c         = 1'b0;
    txd_c         = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c         = 1'b1;
          shreg_next    = fifo_dout;
          byte_idx_next = '0;
          baud_cnt_next = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        txd_c = 1'b0;
        if (baud_tick_c) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = ST_DATA;
        end else begin
          baud_cnt_next = baud_cnt + DIV_W'(1);
        end
      end
      ST_DATA: begin
        txd_c = shreg[0];
        if (baud_tick_c) begin
          baud_cnt_next = '0;
          shreg_next    = shreg >> 1;
          if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) state_next = ST_STOP;
          else bit_idx_next = bit_idx + BIT_W'(1);
        end else begin
          baud_cnt_next = baud_cnt + DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_tick_c) begin
          baud_cnt_next = '0;
          if (byte_idx == BYTE_W'(NONCE_BYTES - 1)) begin
            state_next = ST_IDLE;
          end else begin
            byte_idx_next = byte_idx + BYTE_W'(1);
            state_next    = ST_START;
          end
        end else begin
          baud_cnt_next = baud_cnt + DIV_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line and status flags are registered; a nonce is dropped only when full with no pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      TxD      <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      TxD      <= txd_c;
      busy     <= (state != ST_IDLE) || !fifo_empty;
      overflow <= new_nonce && fifo_full && !pop_c;
    end
  end

endmodule
